dispense_inventory: RTL and testbench
=====================================

# dispense_inventory

Per-slot inventory keeper and dispense sequencer for the vending datapath. Sits directly downstream of the payment/credit stage and consumes its `reduceInventory` request. For each request it:
- checks the selected slot's stock,
- decrements the slot count and drives the dispense motor for a fixed number of cycles,
- closes the four-phase handshake with `reduceInventoryDone`.

It also accepts service restocks and publishes per-slot sold-out flags back to the front end.

## Interface
Parameters:
- `NUM_ITEMS`, 8: number of slots (max 16).
- `CNT_W`, 4: width of each slot count.
- `INIT_COUNT`, 10: count loaded into every slot at reset.
- `DISPENSE_CYCLES`, 4: cycles `dispense` is held high per vend (≥1).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `reduceInventory`  in  1  vend request (level, four-phase).
- `curIndex`  in  4  slot to vend; sampled with the request.
- `restock`  in  1  restock strobe, one cycle.
- `restockIndex`  in  4  slot to restock.
- `restockQty`  in  CNT_W  units to add.
- `reduceInventoryDone`  out  1  vend complete (level, four-phase).
- `dispense`  out  1  motor drive.
- `dispenseIndex`  out  4  slot being driven; valid while `dispense`=1.
- `dispenseErr`  out  1  one-cycle pulse: vend refused (empty slot or bad index).
- `restockAck`  out  1  one-cycle pulse: restock applied.
- `soldOut`  out  NUM_ITEMS  bit i = slot i count is 0.
- `totalVends`  out  16  vend counter (see Configuration).

## Operation
- All outputs are registered.
- Reset (`rst`=0, asynchronous):
  - every slot count = `INIT_COUNT`;
  - state = IDLE;
  - `reduceInventoryDone`, `dispense`, `dispenseErr`, `restockAck` = 0;
  - `dispenseIndex` = 0;
  - `soldOut` = all ones if `INIT_COUNT`=0, else all zeros;
  - `totalVends` = 0.
- FSM states: IDLE, CHECK, DISPENSE, DONE.
- IDLE:
  - if `reduceInventory`=1, latch `curIndex` and go to CHECK;
  - else, if `restock`=1, apply the restock.
- CHECK:
  - bad index (≥`NUM_ITEMS`) or count 0: go to DONE and pulse `dispenseErr` in the first DONE cycle. No count change.
  - otherwise: decrement the count, go to DISPENSE, load the cycle counter with `DISPENSE_CYCLES`.
- DISPENSE:
  - `dispense`=1 and `dispenseIndex` = latched index;
  - cycle counter decrements;
  - go to DONE when it reaches the last cycle.
- DONE:
  - `reduceInventoryDone`=1 held until `reduceInventory` is sampled 0;
  - then go to IDLE with `reduceInventoryDone`=0 on that edge.
  - A new request is accepted only from IDLE, so a request must drop before the next one can be accepted.
- Restock:
  - accepted only in IDLE with no request present; ignored with no ack in any other state, or when the request wins in IDLE;
  - index ≥`NUM_ITEMS` is ignored with no ack;
  - count = min(count + qty, 2^CNT_W−1), saturating;
  - `restockAck` pulses on the following cycle.
- `soldOut` is recomputed from the counts and is registered one cycle after any count change.
- `curIndex` and `reduceInventory` are sampled only on clock edges, so combinational glitches between edges are ignored.

## Timing
- Request sampled at edge 0.
- CHECK occupies edge 0→1.
- `dispense` rises after edge 1 and stays high exactly `DISPENSE_CYCLES` cycles.
- `reduceInventoryDone` rises after edge 1+`DISPENSE_CYCLES`.
- Refused vend: `dispenseErr` and `reduceInventoryDone` both rise after edge 1; `dispense` never asserts.
- `reduceInventoryDone` falls on the first edge at which `reduceInventory` is sampled 0.
- Reset asserted mid-vend drops `dispense` and `reduceInventoryDone` immediately. A decrement already made in CHECK is discarded because all counts reload.

## Configuration
- Macro: `DISPENSE_INVENTORY_STATS_EN`.
- Defined: `totalVends` increments (wrapping at 16 bits) on each CHECK→DISPENSE transition. Refused vends are not counted.
- Undefined: counter logic is removed and `totalVends` is tied to 0. The port remains.

## Test plan
- Reset, then request slot 3 with `DISPENSE_CYCLES`=4:
  - `dispense` high 4 cycles with `dispenseIndex`=3;
  - done rises 5 cycles after the request is sampled;
  - slot 3 count goes 10→9; `totalVends`=1 with the macro, 0 without.
- Vend slot 0 ten times from `INIT_COUNT`=10:
  - `soldOut[0]`=1 after the tenth vend;
  - the eleventh request gives `dispenseErr` pulse and done after 1 cycle, no `dispense`, count stays 0.
- Request with `curIndex`=9, `NUM_ITEMS`=8: `dispenseErr`=1, no count changes, done handshake completes.
- Restock slot 2 by 9 from count 10: count saturates at 15, `restockAck` pulses once. Restock strobed during DISPENSE: ignored, no ack.
- Hold `reduceInventory` high 6 cycles past done: done stays high, no second vend occurs. Drop the request: done falls on the next edge.
- Assert `rst` low in the second DISPENSE cycle: `dispense` is 0 asynchronously, all counts read 10 after release.

Source files
------------

// File: rtl/dispense_inventory.sv
// Per-slot inventory keeper and four-phase dispense sequencer with service restock.
// Optional vend statistics counter enabled by defining DISPENSE_INVENTORY_STATS_EN.
module dispense_inventory #(
   parameter int NUM_ITEMS       = 8,
   parameter int CNT_W           = 4,
   parameter int INIT_COUNT      = 10,
   parameter int DISPENSE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 reduceInventory,
   input  logic [3:0]           curIndex,
   input  logic                 restock,
   input  logic [3:0]           restockIndex,
   input  logic [CNT_W-1:0]     restockQty,
   output logic                 reduceInventoryDone,
   output logic                 dispense,
   output logic [3:0]           dispenseIndex,
   output logic                 dispenseErr,
   output logic                 restockAck,
   output logic [NUM_ITEMS-1:0] soldOut,
   output logic [15:0]          totalVends
);

   localparam int CYC_W = (DISPENSE_CYCLES < 2) ? 1 : $clog2(DISPENSE_CYCLES + 1);
   localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_COUNT);
   localparam logic [4:0]       NUM_LIM  = 5'(NUM_ITEMS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_DISPENSE,
      S_DONE
   } state_t;

   state_t                          state_q, state_d;
   logic [3:0]                      idx_q, idx_d;
   logic [CYC_W-1:0]                cyc_q, cyc_d;
   logic [NUM_ITEMS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic                            done_q, done_d;
   logic                            disp_q, disp_d;
   logic [3:0]                      disp_idx_q, disp_idx_d;
   logic                            err_q, err_d;
   logic                            ack_q, ack_d;
   logic [NUM_ITEMS-1:0]            sold_q, sold_d;

   logic [CNT_W-1:0]                sel_cnt;
   logic                            idx_ok;
   logic                            rs_ok;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CNT_W] ? '1 : s[CNT_W-1:0];
   endfunction

   assign idx_ok = ({1'b0, idx_q} < NUM_LIM);
   assign rs_ok  = ({1'b0, restockIndex} < NUM_LIM);

   // Mux by comparison so a 4-bit index never addresses past the slot array.
   always_comb begin
      sel_cnt = '0;
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
         if (idx_q == 4'(i)) sel_cnt = cnt_q[i];
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cyc_d   = cyc_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      ack_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (reduceInventory) begin
               idx_d   = curIndex;
               state_d = S_CHECK;
            end else if (restock && rs_ok) begin
               for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                  if (restockIndex == 4'(i)) cnt_d[i] = sat_add(cnt_q[i], restockQty);
               end
               ack_d = 1'b1;
            end
         end
         S_CHECK: begin
            if (!idx_ok || sel_cnt == '0) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                  if (idx_q == 4'(i)) cnt_d[i] = cnt_q[i] - CNT_W'(1);
               end
               cyc_d   = CYC_W'(DISPENSE_CYCLES);
               state_d = S_DISPENSE;
            end
         end
         S_DISPENSE: begin
            if (cyc_q <= CYC_W'(1)) begin
               state_d = S_DONE;
            end else begin
               cyc_d = cyc_q - CYC_W'(1);
            end
         end
         S_DONE: begin
            if (!reduceInventory) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      done_d     = (state_d == S_DONE);
      disp_d     = (state_d == S_DISPENSE);
      disp_idx_d = (state_d == S_DISPENSE) ? idx_d : '0;

      // Flags follow the registered counts, so they trail a count change by one cycle.
      for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
         sold_d[i] = (cnt_q[i] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         cyc_q      <= '0;
         cnt_q      <= {NUM_ITEMS{INIT_CNT}};
         done_q     <= 1'b0;
         disp_q     <= 1'b0;
         disp_idx_q <= '0;
         err_q      <= 1'b0;
         ack_q      <= 1'b0;
         sold_q     <= (INIT_COUNT == 0) ? '1 : '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cyc_q      <= cyc_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         disp_q     <= disp_d;
         disp_idx_q <= disp_idx_d;
         err_q      <= err_d;
         ack_q      <= ack_d;
         sold_q     <= sold_d;
      end
   end

   assign reduceInventoryDone = done_q;
   assign dispense            = disp_q;
   assign dispenseIndex       = disp_idx_q;
   assign dispenseErr         = err_q;
   assign restockAck          = ack_q;
   assign soldOut             = sold_q;

`ifdef DISPENSE_INVENTORY_STATS_EN
   logic [15:0] vends_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vends_q <= '0;
      end else if (state_q == S_CHECK && state_d == S_DISPENSE) begin
         vends_q <= vends_q + 16'd1;
      end
   end

   assign totalVends = vends_q;
`else
   assign totalVends = '0;
`endif

endmodule

// File: tb/tb_dispense_inventory.sv
// Self-checking bench for dispense_inventory: vector table, corner sequences and
// randomized traffic checked against a slot-count reference model.
module tb_dispense_inventory;

   localparam int NI = 8;
   localparam int CW = 4;
   localparam int IC = 10;
   localparam int DC = 4;
   localparam int MAXC = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          reduceInventory;
   logic [3:0]    curIndex;
   logic          restock;
   logic [3:0]    restockIndex;
   logic [CW-1:0] restockQty;
   logic          reduceInventoryDone;
   logic          dispense;
   logic [3:0]    dispenseIndex;
   logic          dispenseErr;
   logic          restockAck;
   logic [NI-1:0] soldOut;
   logic [15:0]   totalVends;

   int checks = 0;
   int errors = 0;

   int mcnt[NI];
   int mvends;

   dispense_inventory #(
      .NUM_ITEMS(NI),
      .CNT_W(CW),
      .INIT_COUNT(IC),
      .DISPENSE_CYCLES(DC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .reduceInventory(reduceInventory),
      .curIndex(curIndex),
      .restock(restock),
      .restockIndex(restockIndex),
      .restockQty(restockQty),
      .reduceInventoryDone(reduceInventoryDone),
      .dispense(dispense),
      .dispenseIndex(dispenseIndex),
      .dispenseErr(dispenseErr),
      .restockAck(restockAck),
      .soldOut(soldOut),
      .totalVends(totalVends)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [NI-1:0] model_sold();
      logic [NI-1:0] s;
      for (int i = 0; i < NI; i++) s[i] = (mcnt[i] == 0);
      return s;
   endfunction

   function automatic logic [15:0] model_vends();
`ifdef DISPENSE_INVENTORY_STATS_EN
      return 16'(mvends);
`else
      return 16'd0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NI; i++) mcnt[i] = IC;
      mvends = 0;
   endtask

   // Full four-phase vend; ok is the expected acceptance, hold adds cycles of request
   // held past done, rs_at strobes a restock of the same slot before edge rs_at (-1: none).
   task automatic vend(input int idx, input bit ok, input int hold, input int rs_at);
      int last;
      last = (ok ? DC + 1 : 1) + hold;
      @(negedge clk);
      reduceInventory = 1'b1;
      curIndex        = 4'(idx);
      restock         = (rs_at == 0);
      restockIndex    = 4'(idx);
      restockQty      = 4'd3;
      for (int e = 0; e <= last; e++) begin
         @(negedge clk);
         chk("dispense", dispense, (ok && e >= 1 && e <= DC));
         if (ok && e >= 1 && e <= DC) chk("dispenseIndex", dispenseIndex, idx);
         chk("done", reduceInventoryDone, ok ? (e >= DC + 1) : (e >= 1));
         chk("dispenseErr", dispenseErr, (!ok && e == 1));
         chk("restockAck_vend", restockAck, 0);
         restock  = (rs_at == e + 1);
         curIndex = 4'($urandom_range(0, 15));
      end
      reduceInventory = 1'b0;
      restock         = 1'b0;
      @(negedge clk);
      chk("done_fall", reduceInventoryDone, 0);
      chk("dispense_idle", dispense, 0);
      if (idx < NI && mcnt[idx] > 0) begin
         mcnt[idx]--;
         mvends++;
      end
      chk("soldOut_vend", soldOut, model_sold());
      chk("totalVends", totalVends, model_vends());
   endtask

   task automatic do_restock(input int idx, input int qty);
      @(negedge clk);
      restock      = 1'b1;
      restockIndex = 4'(idx);
      restockQty   = 4'(qty);
      @(negedge clk);
      chk("restockAck", restockAck, (idx < NI));
      restock = 1'b0;
      if (idx < NI) mcnt[idx] = (mcnt[idx] + qty > MAXC) ? MAXC : mcnt[idx] + qty;
      @(negedge clk);
      chk("restockAck_pulse", restockAck, 0);
      chk("soldOut_restock", soldOut, model_sold());
   endtask

   typedef struct {
      int idx;
      int hold;
      int rs_at;
      bit exp_ok;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{idx: 3,  hold: 0, rs_at: -1, exp_ok: 1'b1};
      vecs[1] = '{idx: 9,  hold: 0, rs_at: -1, exp_ok: 1'b0};
      vecs[2] = '{idx: 15, hold: 0, rs_at: -1, exp_ok: 1'b0};
      vecs[3] = '{idx: 4,  hold: 0, rs_at: 2,  exp_ok: 1'b1};
      vecs[4] = '{idx: 6,  hold: 6, rs_at: -1, exp_ok: 1'b1};
      vecs[5] = '{idx: 1,  hold: 0, rs_at: 0,  exp_ok: 1'b1};
      vecs[6] = '{idx: 8,  hold: 1, rs_at: -1, exp_ok: 1'b0};
      vecs[7] = '{idx: 7,  hold: 0, rs_at: -1, exp_ok: 1'b1};

      rst             = 1'b1;
      reduceInventory = 1'b0;
      curIndex        = '0;
      restock         = 1'b0;
      restockIndex    = '0;
      restockQty      = '0;
      model_reset();

      #3 rst = 1'b0;
      #1;
      chk("rst_done", reduceInventoryDone, 0);
      chk("rst_dispense", dispense, 0);
      chk("rst_err", dispenseErr, 0);
      chk("rst_ack", restockAck, 0);
      chk("rst_index", dispenseIndex, 0);
      chk("rst_soldOut", soldOut, 0);
      chk("rst_totalVends", totalVends, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int v = 0; v < 8; v++) begin
         vend(vecs[v].idx, vecs[v].exp_ok, vecs[v].hold, vecs[v].rs_at);
      end

      // Drain slot 0, then one refused request on the empty slot.
      for (int n = 0; n < 10; n++) vend(0, 1'b1, 0, -1);
      chk("soldOut0_set", soldOut[0], 1);
      vend(0, 1'b0, 0, -1);
      chk("soldOut0_stays", soldOut[0], 1);

      // Saturating restock: 10 + 9 clamps to 15, observed as 15 good vends then a refusal.
      do_restock(2, 9);
      do_restock(12, 5);
      for (int n = 0; n < 15; n++) vend(2, 1'b1, 0, -1);
      vend(2, 1'b0, 0, -1);

      for (int n = 0; n < 40; n++) begin
         int op;
         int idx;
         op = int'($urandom_range(0, 2));
         idx = int'($urandom_range(0, 9));
         if (op < 2) begin
            vend(idx, (idx < NI) && (mcnt[idx] > 0), int'($urandom_range(0, 2)), -1);
         end else begin
            do_restock(idx, int'($urandom_range(0, 15)));
         end
      end

      // Reset in the second DISPENSE cycle.
      @(negedge clk);
      reduceInventory = 1'b1;
      curIndex        = 4'd5;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("mid_dispense", dispense, (mcnt[5] > 0));
      rst = 1'b0;
      #1;
      chk("async_dispense", dispense, 0);
      chk("async_done", reduceInventoryDone, 0);
      reduceInventory = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      chk("post_rst_soldOut", soldOut, 0);
      chk("post_rst_totalVends", totalVends, 0);
      for (int n = 0; n < 10; n++) vend(0, 1'b1, 0, -1);
      vend(0, 1'b0, 0, -1);
      chk("post_rst_soldOut0", soldOut[0], 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
